// File: rtl/int_controller_pkg.sv
// Shared types and helpers for the Z80 maskable-interrupt controller.
package int_controller_pkg;

    typedef enum logic {
        INT_MODE_PULSE,
        INT_MODE_LATCHED
    } int_mode_t;

    typedef enum logic [1:0] {
        INT_IDLE,
        INT_ASSERT,
        INT_ACK,
        INT_RECOVER
    } int_state_t;

    // IM2 vectors are word-aligned per channel and wrap at 8 bits.
    function automatic logic [7:0] int_vector(input logic [7:0] base, input int unsigned ch);
        logic [7:0] ofs;
        ofs = 8'(ch << 1);
        return base + ofs;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module int_prio_enc #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] valid,
    output logic                any_valid,
    output logic [IDX_W-1:0]    index
);

    always_comb begin
        any_valid = |valid;
        index     = '0;
        // Scan downwards so the lowest set bit is the last to write.
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (valid[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_controller.sv
// Multi-channel Z80 /INT generator with fixed priority, pulse/latched modes and IM2 vectors.
module int_controller
    import int_controller_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 6,
    parameter logic [7:0]  VECTOR_BASE = 8'hF0
) (
    input  logic                clkcpu,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] req,
    input  logic [CHANNELS-1:0] en,
    input  int_mode_t           mode,
    input  logic [CNT_W-1:0]    pulse_len,
    input  logic                m1,
    input  logic                iorq,
    output logic                n_int,
    output logic [7:0]          vector,
    output logic                vector_oe,
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] missed,
    input  logic [CHANNELS-1:0] missed_clr
);

    localparam int unsigned IdxW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    int_state_t          state_q, state_d;
    logic [IdxW-1:0]     cur_ch_q, cur_ch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    int_mode_t           mode_q, mode_d;
    logic                n_int_q, n_int_d;
    logic [7:0]          vector_q, vector_d;
    logic                vector_oe_q, vector_oe_d;
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] missed_q, missed_d;

    logic [CHANNELS-1:0] cand;
    logic                any_valid;
    logic [IdxW-1:0]     sel_idx;
    logic [CHANNELS-1:0] cur_onehot;
    logic [CNT_W-1:0]    load_val;
    logic                svc_clr;
    logic                miss_set;

    // Fresh strobes are visible to the arbiter in the same cycle they are latched,
    // giving one cycle from req to /INT low when idle.
    assign cand     = (pending_q | req) & en;
    assign load_val = (pulse_len == '0) ? CNT_W'(1) : pulse_len;

    int_prio_enc #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IdxW)
    ) u_prio_enc (
        .valid     (cand),
        .any_valid (any_valid),
        .index     (sel_idx)
    );

    always_comb begin
        for (int k = 0; k < int'(CHANNELS); k++) begin
            cur_onehot[k] = (cur_ch_q == IdxW'(k));
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        n_int_d     = n_int_q;
        vector_d    = vector_q;
        vector_oe_d = vector_oe_q;
        svc_clr     = 1'b0;
        miss_set    = 1'b0;

        unique case (state_q)
            INT_IDLE: begin
                if (any_valid) begin
                    cur_ch_d = sel_idx;
                    cnt_d    = load_val;
                    mode_d   = mode;
                    n_int_d  = 1'b0;
                    state_d  = INT_ASSERT;
                end
            end
            INT_ASSERT: begin
                if (m1 && iorq) begin
                    n_int_d     = 1'b1;
                    vector_d    = int_vector(VECTOR_BASE, 32'(cur_ch_q));
                    vector_oe_d = 1'b1;
                    svc_clr     = 1'b1;
                    state_d     = INT_ACK;
                end else if (!en[cur_ch_q]) begin
                    n_int_d = 1'b1;
                    state_d = INT_RECOVER;
                end else if (cnt_q == CNT_W'(1)) begin
                    // Latched mode parks here with the counter at 1 until acknowledged.
                    if (mode_q == INT_MODE_PULSE) begin
                        n_int_d  = 1'b1;
                        svc_clr  = 1'b1;
                        miss_set = 1'b1;
                        state_d  = INT_RECOVER;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            INT_ACK: begin
                if (!iorq) begin
                    vector_oe_d = 1'b0;
                    state_d     = INT_RECOVER;
                end
            end
            INT_RECOVER: begin
                state_d = INT_IDLE;
            end
            default: begin
                state_d = INT_IDLE;
            end
        endcase

        pending_d = ((pending_q & ~(svc_clr ? cur_onehot : '0)) | req) & en;
        missed_d  = (missed_q & ~missed_clr) | (miss_set ? cur_onehot : '0);
    end

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INT_IDLE;
            cur_ch_q    <= '0;
            cnt_q       <= '0;
            mode_q      <= INT_MODE_PULSE;
            n_int_q     <= 1'b1;
            vector_q    <= VECTOR_BASE;
            vector_oe_q <= 1'b0;
            pending_q   <= '0;
            missed_q    <= '0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            n_int_q     <= n_int_d;
            vector_q    <= vector_d;
            vector_oe_q <= vector_oe_d;
            pending_q   <= pending_d;
            missed_q    <= missed_d;
        end
    end

    assign n_int     = n_int_q;
    assign vector    = vector_q;
    assign vector_oe = vector_oe_q;
    assign pending   = pending_q;
    assign missed    = missed_q;

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: directed scenarios plus randomized pulse/latched runs.
module tb_int_controller;
    import int_controller_pkg::*;

    localparam int unsigned CH = 4;
    localparam int unsigned CW = 6;
    localparam logic [7:0]  VB = 8'hF0;

    logic          clkcpu = 1'b0;
    logic          rst_n;
    logic [CH-1:0] req;
    logic [CH-1:0] en;
    int_mode_t     mode;
    logic [CW-1:0] pulse_len;
    logic          m1;
    logic          iorq;
    logic          n_int;
    logic [7:0]    vector;
    logic          vector_oe;
    logic [CH-1:0] pending;
    logic [CH-1:0] missed;
    logic [CH-1:0] missed_clr;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clkcpu = ~clkcpu;

    int_controller #(
        .CHANNELS    (CH),
        .CNT_W       (CW),
        .VECTOR_BASE (VB)
    ) dut (
        .clkcpu     (clkcpu),
        .rst_n      (rst_n),
        .req        (req),
        .en         (en),
        .mode       (mode),
        .pulse_len  (pulse_len),
        .m1         (m1),
        .iorq       (iorq),
        .n_int      (n_int),
        .vector     (vector),
        .vector_oe  (vector_oe),
        .pending    (pending),
        .missed     (missed),
        .missed_clr (missed_clr)
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clkcpu);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; en = '1; mode = INT_MODE_PULSE; pulse_len = '0;
        m1 = 1'b0; iorq = 1'b0; missed_clr = '0;
        #12;
        tests_run++;
        if (n_int !== 1'b1) begin tests_failed++; $display("FAIL reset_n_int got %b want 1", n_int); end
        tests_run++;
        if (vector_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_oe got %b want 0", vector_oe); end
        tests_run++;
        if (vector !== VB) begin tests_failed++; $display("FAIL reset_vector got %h want %h", vector, VB); end
        tests_run++;
        if (pending !== '0 || missed !== '0) begin
            tests_failed++;
            $display("FAIL reset_flags got pend=%b miss=%b want 0/0", pending, missed);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // Single no-ack pulse on channel 0; measures the low time.
    task automatic test_pulse(input int len, input int want);
        int low;
        mode = INT_MODE_PULSE; pulse_len = CW'(len);
        req = 4'b0001;
        tick();
        req = '0;
        tests_run++;
        if (n_int !== 1'b0) begin tests_failed++; $display("FAIL pulse_latency len=%0d got %b want 0", len, n_int); end
        low = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (n_int !== 1'b0) break;
            low++;
        end
        tests_run++;
        if (low != want) begin tests_failed++; $display("FAIL pulse_len len=%0d got %0d want %0d", len, low, want); end
        tests_run++;
        if (missed !== 4'b0001 || pending !== '0) begin
            tests_failed++;
            $display("FAIL pulse_flags got miss=%b pend=%b want 0001/0000", missed, pending);
        end
        tick();
    endtask

    task automatic test_latched_ack();
        int bad = 0;
        missed_clr = '1; tick(); missed_clr = '0;
        mode = INT_MODE_LATCHED; pulse_len = CW'(3);
        req = 4'b0100;
        tick();
        req = '0;
        for (int i = 0; i < 99; i++) begin
            if (n_int !== 1'b0) bad++;
            tick();
        end
        if (n_int !== 1'b0) bad++;
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL latched_hold got %0d high samples want 0", bad); end
        m1 = 1'b1; iorq = 1'b1;
        tick();
        tests_run++;
        if (n_int !== 1'b1 || vector_oe !== 1'b1 || vector !== 8'hF4) begin
            tests_failed++;
            $display("FAIL latched_ack got n_int=%b oe=%b vec=%h want 1/1/f4", n_int, vector_oe, vector);
        end
        tick();
        tests_run++;
        if (vector_oe !== 1'b1) begin tests_failed++; $display("FAIL latched_oe_hold got %b want 1", vector_oe); end
        m1 = 1'b0; iorq = 1'b0;
        tick();
        tests_run++;
        if (vector_oe !== 1'b0 || pending !== '0 || missed !== '0) begin
            tests_failed++;
            $display("FAIL latched_end got oe=%b pend=%b miss=%b want 0/0/0", vector_oe, pending, missed);
        end
        tick(); tick();
    endtask

    task automatic test_priority();
        int high;
        mode = INT_MODE_LATCHED; pulse_len = CW'(2);
        req = 4'b1010;
        tick();
        req = '0;
        tick();
        m1 = 1'b1; iorq = 1'b1;
        tick();
        m1 = 1'b0; iorq = 1'b0;
        tests_run++;
        if (vector !== 8'hF2 || pending !== 4'b1000) begin
            tests_failed++;
            $display("FAIL prio_first got vec=%h pend=%b want f2/1000", vector, pending);
        end
        high = 0;
        for (int i = 0; i < 10; i++) begin
            if (n_int !== 1'b1) break;
            high++;
            tick();
        end
        // ACK (1 cycle) + RECOVER + IDLE
        tests_run++;
        if (high != 3) begin tests_failed++; $display("FAIL prio_gap got %0d want 3", high); end
        m1 = 1'b1; iorq = 1'b1;
        tick();
        m1 = 1'b0; iorq = 1'b0;
        tests_run++;
        if (vector !== 8'hF6 || pending !== '0) begin
            tests_failed++;
            $display("FAIL prio_second got vec=%h pend=%b want f6/0000", vector, pending);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_disable();
        mode = INT_MODE_PULSE; pulse_len = CW'(20);
        req = 4'b0001;
        tick();
        req = '0;
        tick(); tick();
        en = 4'b1110;
        tick();
        tests_run++;
        if (n_int !== 1'b1 || pending !== '0 || missed !== '0) begin
            tests_failed++;
            $display("FAIL disable got n_int=%b pend=%b miss=%b want 1/0/0", n_int, pending, missed);
        end
        en = '1;
        tick(); tick();
    endtask

    task automatic test_random_pulse();
        bit exp_q[$];
        int unsigned mask, len, ln;
        int bad;
        for (int it = 0; it < 6; it++) begin
            mask = $urandom_range(1, 15);
            len  = $urandom_range(0, 12);
            ln   = (len == 0) ? 1 : len;
            exp_q.delete();
            for (int k = 0; k < 4; k++) begin
                if (mask[k]) begin
                    for (int j = 0; j < int'(ln); j++) exp_q.push_back(1'b0);
                    exp_q.push_back(1'b1);
                    exp_q.push_back(1'b1);
                end
            end
            mode = INT_MODE_PULSE; pulse_len = CW'(len);
            req = CH'(mask);
            tick();
            req = '0;
            bad = 0;
            foreach (exp_q[j]) begin
                if (n_int !== exp_q[j]) bad++;
                tick();
            end
            tests_run++;
            if (bad != 0) begin
                tests_failed++;
                $display("FAIL rand_pulse_wave mask=%b len=%0d got %0d bad samples want 0", mask[3:0], len, bad);
            end
            tests_run++;
            if (missed !== CH'(mask) || pending !== '0) begin
                tests_failed++;
                $display("FAIL rand_pulse_flags got miss=%b pend=%b want %b/0000", missed, pending, mask[3:0]);
            end
            missed_clr = '1; tick(); missed_clr = '0;
        end
    endtask

    task automatic test_random_latched();
        int unsigned mask, d, h, w, bad;
        logic [CH-1:0] exp_pend;
        for (int it = 0; it < 4; it++) begin
            mask = $urandom_range(1, 15);
            mode = INT_MODE_LATCHED; pulse_len = CW'($urandom_range(0, 5));
            req = CH'(mask);
            tick();
            req = '0;
            for (int k = 0; k < 4; k++) begin
                if (!mask[k]) continue;
                w = 0;
                while (n_int !== 1'b0 && w < 8) begin tick(); w++; end
                tests_run++;
                if (w >= 8) begin tests_failed++; $display("FAIL rand_lat_wait ch=%0d got timeout want low", k); end
                d = $urandom_range(1, 15);
                bad = 0;
                for (int i = 1; i < int'(d); i++) begin tick(); if (n_int !== 1'b0) bad++; end
                m1 = 1'b1; iorq = 1'b1;
                h = $urandom_range(1, 3);
                tick();
                exp_pend = CH'(mask) & ~CH'((2 << k) - 1);
                tests_run++;
                if (bad != 0 || n_int !== 1'b1 || vector !== 8'(VB + 2 * k) || pending !== exp_pend) begin
                    tests_failed++;
                    $display("FAIL rand_lat_ack ch=%0d got bad=%0d n_int=%b vec=%h pend=%b want 0/1/%h/%b",
                             k, bad, n_int, vector, pending, 8'(VB + 2 * k), exp_pend);
                end
                m1 = 1'b0;
                bad = 0;
                for (int i = 1; i < int'(h); i++) begin tick(); if (vector_oe !== 1'b1) bad++; end
                iorq = 1'b0;
                tick();
                tests_run++;
                if (bad != 0 || vector_oe !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rand_lat_oe ch=%0d got bad=%0d oe=%b want 0/0", k, bad, vector_oe);
                end
            end
            tick(); tick();
            tests_run++;
            if (missed !== '0 || pending !== '0 || n_int !== 1'b1) begin
                tests_failed++;
                $display("FAIL rand_lat_end got miss=%b pend=%b n_int=%b want 0/0/1", missed, pending, n_int);
            end
        end
    endtask

    task automatic test_reset_in_ack();
        int bad = 0;
        mode = INT_MODE_PULSE; pulse_len = CW'(1);
        req = 4'b1000;
        tick(); req = '0;
        tick(); tick(); tick();
        mode = INT_MODE_LATCHED;
        req = 4'b0011;
        tick(); req = '0;
        m1 = 1'b1; iorq = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (n_int !== 1'b1 || vector_oe !== 1'b0 || pending !== '0 || missed !== '0) begin
            tests_failed++;
            $display("FAIL async_reset got n_int=%b oe=%b pend=%b miss=%b want 1/0/0/0",
                     n_int, vector_oe, pending, missed);
        end
        m1 = 1'b0; iorq = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin tick(); if (n_int !== 1'b1) bad++; end
        tests_run++;
        if (bad != 0 || vector !== VB) begin
            tests_failed++;
            $display("FAIL post_reset_idle got bad=%0d vec=%h want 0/%h", bad, vector, VB);
        end
    endtask

    initial begin
        test_reset();
        test_pulse(32, 32);
        test_pulse(0, 1);
        test_latched_ack();
        test_priority();
        test_disable();
        test_random_pulse();
        test_random_latched();
        test_reset_in_ack();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
